// File: rtl/shift_reg_pkg.sv
// rtl/shift_reg_pkg.sv - mode constants and state/op types for the universal shift register
package shift_reg_pkg;

  localparam logic [2:0] MODE_SHIFT  = 3'b000;
  localparam logic [2:0] MODE_ROTATE = 3'b001;
  localparam logic [2:0] MODE_LOAD   = 3'b010;
  localparam logic [2:0] MODE_HOLD   = 3'b011;
  localparam logic [2:0] MODE_ASHIFT = 3'b100;
  localparam logic [2:0] MODE_TX     = 3'b101;
  localparam logic [2:0] MODE_RX     = 3'b110;
  localparam logic [2:0] MODE_RSVD   = 3'b111;

  typedef enum logic {IDLE, XFER} state_e;
  typedef enum logic {TX, RX} xfer_e;
  typedef enum logic [1:0] {OP_LOGIC, OP_ROTATE, OP_ARITH} shift_op_e;

endpackage

// File: rtl/shift_reg_unit.sv
// rtl/shift_reg_unit.sv - combinational one-position shifter shared by all shifting modes
module shift_reg_unit
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q_i,
  input  logic             dir_i,
  input  shift_op_e        op_i,
  input  logic             fill_i,
  output logic [WIDTH-1:0] q_o,
  output logic             bit_o
);

  logic in_bit;

  always_comb begin
    bit_o = dir_i ? q_i[0] : q_i[WIDTH-1];
    case (op_i)
      OP_ROTATE: in_bit = bit_o;
      // Arithmetic right replicates the sign; arithmetic left zero-fills.
      OP_ARITH:  in_bit = dir_i ? q_i[WIDTH-1] : 1'b0;
      default:   in_bit = fill_i;
    endcase
    q_o = dir_i ? {in_bit, q_i[WIDTH-1:1]} : {q_i[WIDTH-2:0], in_bit};
  end

endmodule

// File: rtl/shift_reg_param.sv
// rtl/shift_reg_param.sv - universal shift register with self-timed serial TX/RX
module shift_reg_param
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enb,
  input  logic             dir,
  input  logic [2:0]       mode,
  input  logic             s_in,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             s_out,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_e           state_q;
  xfer_e            type_q;
  logic             dir_lat_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] q_q;
  logic             s_out_q;
  logic             busy_q;
  logic             done_q;

  logic             u_dir;
  shift_op_e        u_op;
  logic             u_fill;
  logic [WIDTH-1:0] u_q;
  logic             u_bit;

  // During a transfer the latched direction and type steer the shared shifter.
  always_comb begin
    u_dir  = (state_q == XFER) ? dir_lat_q : dir;
    u_op   = OP_LOGIC;
    u_fill = s_in;
    if (state_q == XFER) begin
      if (type_q == TX) u_fill = 1'b0;
    end else if (mode == MODE_ROTATE) begin
      u_op = OP_ROTATE;
    end else if (mode == MODE_ASHIFT) begin
      u_op = OP_ARITH;
    end
  end

  shift_reg_unit #(.WIDTH(WIDTH)) u_unit (
    .q_i    (q_q),
    .dir_i  (u_dir),
    .op_i   (u_op),
    .fill_i (u_fill),
    .q_o    (u_q),
    .bit_o  (u_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      type_q    <= TX;
      dir_lat_q <= 1'b0;
      cnt_q     <= '0;
      q_q       <= '0;
      s_out_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (enb) begin
        if (state_q == XFER) begin
          q_q     <= u_q;
          s_out_q <= (type_q == TX) ? u_bit : 1'b0;
          cnt_q   <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end else begin
          case (mode)
            MODE_SHIFT, MODE_ASHIFT: begin
              q_q     <= u_q;
              s_out_q <= u_bit;
            end
            MODE_ROTATE: begin
              q_q     <= u_q;
              s_out_q <= 1'b0;
            end
            MODE_LOAD: begin
              q_q     <= d;
              s_out_q <= 1'b0;
            end
            MODE_TX: begin
              q_q       <= d;
              cnt_q     <= CNT_W'(WIDTH);
              busy_q    <= 1'b1;
              dir_lat_q <= dir;
              type_q    <= TX;
              state_q   <= XFER;
            end
            MODE_RX: begin
              q_q       <= '0;
              s_out_q   <= 1'b0;
              cnt_q     <= CNT_W'(WIDTH);
              busy_q    <= 1'b1;
              dir_lat_q <= dir;
              type_q    <= RX;
              state_q   <= XFER;
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign q     = q_q;
  assign s_out = s_out_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_shift_reg_param.sv
// tb/tb_shift_reg_param.sv - self-checking bench for shift_reg_param against a behavioural model
module tb_shift_reg_param;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n, enb, dir, s_in;
  logic [2:0]   mode;
  logic [W-1:0] d, q;
  logic         s_out, busy, done;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  shift_reg_param #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .enb   (enb),
    .dir   (dir),
    .mode  (mode),
    .s_in  (s_in),
    .d     (d),
    .q     (q),
    .s_out (s_out),
    .busy  (busy),
    .done  (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: a transfer is tracked as "word and number of bits moved so far".
  logic [W-1:0] m_q, m_word;
  logic         m_sout, m_busy, m_done, m_xfer, m_is_tx, m_dir;
  int           m_k;
  bit           m_rx[$];

  function automatic logic [W-1:0] rx_value();
    logic [W-1:0] v = '0;
    int n = m_rx.size();
    for (int i = 0; i < n; i++) begin
      if (m_dir) v[W-1-(n-1-i)] = m_rx[i];
      else       v[n-1-i]       = m_rx[i];
    end
    return v;
  endfunction

  task automatic model_reset();
    m_q = '0; m_sout = 0; m_busy = 0; m_done = 0; m_xfer = 0; m_k = 0;
    m_rx.delete();
  endtask

  task automatic model_step(input logic e, input logic [2:0] md, input logic dr,
                            input logic si, input logic [W-1:0] dd);
    logic [W-1:0] nq;
    m_done = 0;
    if (!e) return;
    if (m_xfer) begin
      m_k++;
      if (m_is_tx) begin
        m_sout = m_dir ? m_word[m_k-1] : m_word[W-m_k];
        m_q    = m_dir ? (m_word >> m_k) : (m_word << m_k);
      end else begin
        m_sout = 0;
        m_rx.push_back(si);
        m_q = rx_value();
      end
      if (m_k == W) begin
        m_xfer = 0; m_busy = 0; m_done = 1;
      end
    end else begin
      case (md)
        3'd0: begin
          if (dr) begin m_sout = m_q[0]; nq = (m_q >> 1) | (W'(si) << (W-1)); end
          else    begin m_sout = m_q[W-1]; nq = (m_q << 1) | W'(si); end
          m_q = nq;
        end
        3'd1: begin
          if (dr) nq = (m_q >> 1) | (m_q << (W-1));
          else    nq = (m_q << 1) | (m_q >> (W-1));
          m_q = nq; m_sout = 0;
        end
        3'd2: begin m_q = dd; m_sout = 0; end
        3'd4: begin
          if (dr) begin m_sout = m_q[0]; nq = W'($signed(m_q) >>> 1); end
          else    begin m_sout = m_q[W-1]; nq = m_q << 1; end
          m_q = nq;
        end
        3'd5: begin
          m_q = dd; m_word = dd; m_k = 0; m_busy = 1; m_xfer = 1; m_is_tx = 1; m_dir = dr;
        end
        3'd6: begin
          m_q = '0; m_sout = 0; m_k = 0; m_busy = 1; m_xfer = 1; m_is_tx = 0; m_dir = dr;
          m_rx.delete();
        end
        default: ;
      endcase
    end
  endtask

  task automatic step(input string tag, input logic e, input logic [2:0] md, input logic dr,
                      input logic si, input logic [W-1:0] dd);
    @(negedge clk);
    enb = e; mode = md; dir = dr; s_in = si; d = dd;
    model_step(e, md, dr, si, dd);
    @(posedge clk);
    #1;
    check({tag, "_q"}, q, m_q);
    check({tag, "_sout"}, s_out, m_sout);
    check({tag, "_busy"}, busy, m_busy);
    check({tag, "_done"}, done, m_done);
  endtask

  initial begin
    logic [7:0] rx_bits;
    logic [7:0] got;
    int nbits, nbusy, ndone;

    rst_n = 0; enb = 0; dir = 0; s_in = 0; mode = 3'd3; d = '0;
    model_reset();
    #12;
    check("rst_q", q, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    @(negedge clk); rst_n = 1;

    step("load", 1, 3'd2, 0, 0, 8'hA5);
    step("shl", 1, 3'd0, 0, 1, 8'h00);
    check("shl_lit_q", q, 8'h4B); check("shl_lit_sout", s_out, 1'b1);
    step("shr", 1, 3'd0, 1, 0, 8'h00);
    check("shr_lit_q", q, 8'h25); check("shr_lit_sout", s_out, 1'b1);

    step("load96", 1, 3'd2, 0, 0, 8'h96);
    step("asr", 1, 3'd4, 1, 1, 8'h00);
    check("asr_lit_q", q, 8'hCB); check("asr_lit_sout", s_out, 1'b0);
    step("load81", 1, 3'd2, 0, 0, 8'h81);
    step("ror", 1, 3'd1, 1, 1, 8'h00);
    check("ror_lit_q", q, 8'hC0); check("ror_lit_sout", s_out, 1'b0);
    step("hold", 1, 3'd3, 0, 1, 8'h33);
    check("hold_lit_q", q, 8'hC0);
    step("rsvd", 1, 3'd7, 1, 1, 8'h33);
    check("rsvd_lit_q", q, 8'hC0);
    step("enb0", 0, 3'd2, 0, 0, 8'h11);
    check("enb0_lit_q", q, 8'hC0);

    // TX MSB first, then the same with a two-cycle stall mid-stream
    for (int rep = 0; rep < 2; rep++) begin
      step("txs", 1, 3'd5, 0, 0, 8'hB4);
      nbits = 0; nbusy = busy ? 1 : 0; ndone = 0; got = '0;
      for (int c = 0; c < 8 + 2*rep; c++) begin
        logic e;
        e = !(rep == 1 && (c == 3 || c == 4));
        step("tx", e, 3'd2, 1, 1, 8'hFF);
        if (e) begin
          got = {got[6:0], s_out};
          nbits++;
          if (nbits == 8) check("tx_done_last", done, 1'b1);
        end
        if (busy) nbusy++;
        if (done) ndone++;
      end
      check("tx_bits", got, 8'hB4);
      check("tx_busy_cycles", nbusy, 8 + 2*rep);
      check("tx_done_count", ndone, 1);
    end

    step("rxs", 1, 3'd6, 1, 0, 8'h00);
    rx_bits = 8'b01011010;
    for (int i = 0; i < 8; i++) step("rx", 1, 3'd2, 0, rx_bits[i], 8'hFF);
    check("rx_lit_q", q, 8'h5A); check("rx_lit_done", done, 1'b1);

    // Back-to-back transfers, new start issued while done is high
    step("b2b_s", 1, 3'd5, 1, 0, 8'h3C);
    for (int i = 0; i < 8; i++) step("b2b_a", 1, 3'd3, 0, 0, 8'h00);
    step("b2b_s2", 1, 3'd5, 0, 0, 8'hC3);
    check("b2b_lit_busy", busy, 1'b1); check("b2b_lit_done", done, 1'b0);
    for (int i = 0; i < 8; i++) step("b2b_b", 1, 3'd3, 0, 0, 8'h00);

    // Reset mid-transfer between edges
    step("rtx", 1, 3'd5, 0, 0, 8'hFF);
    step("rtx1", 1, 3'd3, 0, 0, 8'h00);
    step("rtx2", 1, 3'd3, 0, 0, 8'h00);
    rst_n = 0;
    model_reset();
    #2;
    check("arst_q", q, 8'h00); check("arst_sout", s_out, 1'b0);
    check("arst_busy", busy, 1'b0); check("arst_done", done, 1'b0);
    @(negedge clk); rst_n = 1;
    for (int i = 0; i < 10; i++) step("post_rst", 1, 3'd3, 0, 0, 8'h00);

    for (int i = 0; i < 400; i++)
      step("rnd", ($urandom_range(0, 9) != 0), 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
